time_scan: RTL and testbench

TIME_SCAN -- requirements
Module: time_scan

---
 rtl/time_scan.sv | 187 ++++++++++++++++++
 tb/tb_time_scan.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/time_scan.sv
// time_scan: sweeps three time counters (sec, min, hr) over a shared read bus,
// converts each 6-bit binary value to two BCD digits by repeated subtraction,
// commits all three values atomically, and multiplexes them onto a 6-digit
// 7-segment display.
//
// Ports
//   clk        : system clock, all state updates on posedge
//   clear_n    : synchronous active-low reset
//   databus    : shared counter read bus (driven by the counter whose en bit is high)
//   en         : one-hot counter read enables {hour, minute, second}
//   ss, mm, hh : committed BCD values {tens, units}
//   frame_done : one-cycle pulse in the cycle ss/mm/hh take new values
//   dig_sel    : one-hot digit select, bit0 = ss units ... bit5 = hh tens
//   seg        : active-high segments {g,f,e,d,c,b,a} for the selected digit
module time_scan #(
  parameter int SCAN_PERIOD = 1024,
  parameter int DIG_PERIOD  = 256
) (
  input  logic       clk,
  input  logic       clear_n,
  input  logic [5:0] databus,
  output logic [2:0] en,
  output logic [7:0] ss,
  output logic [7:0] mm,
  output logic [7:0] hh,
  output logic       frame_done,
  output logic [5:0] dig_sel,
  output logic [6:0] seg
);

  localparam logic [15:0] SCAN_LAST = 16'(SCAN_PERIOD - 1);
  localparam logic [15:0] DIG_LAST  = 16'(DIG_PERIOD - 1);

  typedef enum logic [2:0] {IDLE, SELECT, CAPTURE, CONVERT, STORE} state_t;

  function automatic logic [2:0] src_en(input logic [1:0] s);
    case (s)
      2'd0:    src_en = 3'b001;
      2'd1:    src_en = 3'b010;
      2'd2:    src_en = 3'b100;
      default: src_en = 3'b000;
    endcase
  endfunction

  function automatic logic [6:0] seg_dec(input logic [3:0] d);
    case (d)
      4'd0:    seg_dec = 7'h3F;
      4'd1:    seg_dec = 7'h06;
      4'd2:    seg_dec = 7'h5B;
      4'd3:    seg_dec = 7'h4F;
      4'd4:    seg_dec = 7'h66;
      4'd5:    seg_dec = 7'h6D;
      4'd6:    seg_dec = 7'h7D;
      4'd7:    seg_dec = 7'h07;
      4'd8:    seg_dec = 7'h7F;
      4'd9:    seg_dec = 7'h6F;
      default: seg_dec = 7'h00;
    endcase
  endfunction

  // ---------------------------------------------------------------- sweep
  state_t      r_state;
  logic [1:0]  r_src;
  logic [2:0]  r_cvt;
  logic [5:0]  r_work;
  logic [3:0]  r_tens;
  logic [15:0] r_scan;
  logic [2:0]  r_en;
  logic [7:0]  r_sh0, r_sh1;
  logic [7:0]  r_ss, r_mm, r_hh;
  logic        r_frame_done;
  logic [7:0]  w_bcd;

  assign w_bcd = {r_tens, r_work[3:0]};

  always_ff @(posedge clk) begin
    if (!clear_n) r_scan <= '0;
    else          r_scan <= (r_scan == SCAN_LAST) ? '0 : r_scan + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      r_state      <= IDLE;
      r_src        <= 2'd0;
      r_cvt        <= 3'd0;
      r_work       <= 6'd0;
      r_tens       <= 4'd0;
      r_en         <= 3'b000;
      r_sh0        <= 8'h00;
      r_sh1        <= 8'h00;
      r_ss         <= 8'h00;
      r_mm         <= 8'h00;
      r_hh         <= 8'h00;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        IDLE: begin
          // a wrap seen while busy is simply missed; the next one starts a sweep
          if (r_scan == '0) begin
            r_en    <= src_en(r_src);
            r_state <= SELECT;
          end
        end
        // bus settle cycle: enable is up but the bus is not trusted yet
        SELECT: r_state <= CAPTURE;
        CAPTURE: begin
          r_work  <= databus;
          r_tens  <= 4'd0;
          r_cvt   <= 3'd0;
          r_en    <= 3'b000;
          r_state <= CONVERT;
        end
        // six conditional subtract-10 steps cover 0..63 (at most six tens)
        CONVERT: begin
          if (r_work >= 6'd10) begin
            r_work <= r_work - 6'd10;
            r_tens <= r_tens + 4'd1;
          end
          r_cvt <= r_cvt + 3'd1;
          if (r_cvt == 3'd5) r_state <= STORE;
        end
        STORE: begin
          if (r_src == 2'd0) r_sh0 <= w_bcd;
          if (r_src == 2'd1) r_sh1 <= w_bcd;
          if (r_src != 2'd2) begin
            r_src   <= r_src + 2'd1;
            r_en    <= src_en(r_src + 2'd1);
            r_state <= SELECT;
          end else begin
            // hour goes straight from the converter to the output: its shadow
            // would be written on this same edge, so it is never kept
            r_ss         <= r_sh0;
            r_mm         <= r_sh1;
            r_hh         <= w_bcd;
            r_frame_done <= 1'b1;
            r_src        <= 2'd0;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------- display
  logic [15:0] r_ref;
  logic [5:0]  r_dig;
  logic [6:0]  r_seg;
  logic [5:0]  w_dig_next;
  logic [3:0]  w_nib;

  assign w_dig_next = (r_ref == DIG_LAST) ? {r_dig[4:0], r_dig[5]} : r_dig;

  // seg is decoded from the digit that will be selected next cycle so that
  // seg and dig_sel change together
  always_comb begin
    w_nib = 4'd0;
    if      (w_dig_next[0]) w_nib = r_ss[3:0];
    else if (w_dig_next[1]) w_nib = r_ss[7:4];
    else if (w_dig_next[2]) w_nib = r_mm[3:0];
    else if (w_dig_next[3]) w_nib = r_mm[7:4];
    else if (w_dig_next[4]) w_nib = r_hh[3:0];
    else if (w_dig_next[5]) w_nib = r_hh[7:4];
  end

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      r_ref <= '0;
      r_dig <= 6'b000001;
      r_seg <= 7'h3F;
    end else begin
      r_ref <= (r_ref == DIG_LAST) ? '0 : r_ref + 16'd1;
      r_dig <= w_dig_next;
      r_seg <= seg_dec(w_nib);
    end
  end

  assign en         = r_en;
  assign ss         = r_ss;
  assign mm         = r_mm;
  assign hh         = r_hh;
  assign frame_done = r_frame_done;
  assign dig_sel    = r_dig;
  assign seg        = r_seg;

endmodule

// File: tb/tb_time_scan.sv
module tb_time_scan;
  localparam int SP = 64;
  localparam int DP = 4;
  localparam logic [6:0] SEGTAB [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                         7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  logic       clk = 1'b0;
  logic       clear_n = 1'b0;
  logic [5:0] databus;
  logic [2:0] en;
  logic [7:0] ss, mm, hh;
  logic       frame_done;
  logic [5:0] dig_sel;
  logic [6:0] seg;

  time_scan #(.SCAN_PERIOD(SP), .DIG_PERIOD(DP)) dut (
    .clk(clk), .clear_n(clear_n), .databus(databus), .en(en),
    .ss(ss), .mm(mm), .hh(hh), .frame_done(frame_done),
    .dig_sel(dig_sel), .seg(seg)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int t = 0;                  // posedges since reset released (0 while in reset)
  int src_v [3] = '{0, 0, 0}; // counter values: sec, min, hr
  int cv [3] = '{0, 0, 0};    // model of committed values
  logic [6:0] exp_seg = 7'h3F;
  logic       glitch_on = 1'b0;
  logic [5:0] glitch_val = 6'd0;
  logic [2:0] en_q = 3'b000;

  // Counter bus: selected counter drives its value; in glitch mode the bus
  // carries junk in the first cycle an enable is high.
  always @(posedge clk) en_q <= en;
  always_comb begin
    databus = 6'd0;
    if (glitch_on && en != 3'b000 && en != en_q) databus = glitch_val;
    else if (en == 3'b001) databus = 6'(src_v[0]);
    else if (en == 3'b010) databus = 6'(src_v[1]);
    else if (en == 3'b100) databus = 6'(src_v[2]);
  end

  // ---- reference model: everything is a function of t and the sweep phase
  function automatic logic [2:0] exp_en();
    int p;
    if (t == 0) return 3'b000;
    p = (t - 1) % SP;
    if (p == 0 || p == 1)   return 3'b001;
    if (p == 9 || p == 10)  return 3'b010;
    if (p == 18 || p == 19) return 3'b100;
    return 3'b000;
  endfunction

  function automatic logic exp_fd();
    return (t > 0) && ((t - 1) % SP == 27);
  endfunction

  function automatic logic [7:0] bcd(int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [5:0] exp_dig();
    return 6'(1 << ((t / DP) % 6));
  endfunction

  function automatic int nib(int idx, int s, int m, int h);
    case (idx)
      0: return s % 10;
      1: return s / 10;
      2: return m % 10;
      3: return m / 10;
      4: return h % 10;
      default: return h / 10;
    endcase
  endfunction

  task automatic tick();
    logic rel;
    int pv [3];
    rel = clear_n;
    pv = cv;
    @(posedge clk); #1;
    if (!rel) begin
      t = 0;
      cv = '{0, 0, 0};
      exp_seg = 7'h3F;
    end else begin
      t++;
      exp_seg = SEGTAB[nib((t / DP) % 6, pv[0], pv[1], pv[2])];
      if ((t - 1) % SP == 27) cv = src_v;
    end
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    clear_n = 1'b0;
    src_v = '{0, 0, 0};
    repeat (3) tick();
    n_chk++; if (en !== 3'b000) begin n_err++; $display("FAIL reset_en got=%b exp=000", en); end
    n_chk++; if (ss !== 8'h00) begin n_err++; $display("FAIL reset_ss got=%h exp=00", ss); end
    n_chk++; if (mm !== 8'h00) begin n_err++; $display("FAIL reset_mm got=%h exp=00", mm); end
    n_chk++; if (hh !== 8'h00) begin n_err++; $display("FAIL reset_hh got=%h exp=00", hh); end
    n_chk++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL reset_fd got=%b exp=0", frame_done); end
    n_chk++; if (dig_sel !== 6'b000001) begin n_err++; $display("FAIL reset_dig got=%b exp=000001", dig_sel); end
    n_chk++; if (seg !== 7'h3F) begin n_err++; $display("FAIL reset_seg got=%h exp=3f", seg); end
  endtask

  task automatic test_basic_sweep();
    int en_cnt [3] = '{0, 0, 0};
    int fd_t = -1;
    src_v = '{42, 7, 13};
    clear_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      n_chk++; if (en !== exp_en()) begin n_err++; $display("FAIL basic_en t=%0d got=%b exp=%b", t, en, exp_en()); end
      n_chk++; if (frame_done !== exp_fd()) begin n_err++; $display("FAIL basic_fd t=%0d got=%b exp=%b", t, frame_done, exp_fd()); end
      n_chk++; if ({ss, mm, hh} !== {bcd(cv[0]), bcd(cv[1]), bcd(cv[2])}) begin
        n_err++; $display("FAIL basic_out t=%0d got=%h/%h/%h", t, ss, mm, hh);
      end
      for (int b = 0; b < 3; b++) if (en[b] === 1'b1) en_cnt[b]++;
      if (frame_done === 1'b1 && fd_t < 0) fd_t = t;
    end
    for (int b = 0; b < 3; b++) begin
      n_chk++; if (en_cnt[b] != 2) begin n_err++; $display("FAIL basic_en_len bit=%0d got=%0d exp=2", b, en_cnt[b]); end
    end
    // start edge is t=1; frame_done is seen 27 cycles later
    n_chk++; if (fd_t != 28) begin n_err++; $display("FAIL basic_fd_time got=%0d exp=28", fd_t); end
    n_chk++; if (ss !== 8'h42) begin n_err++; $display("FAIL basic_ss got=%h exp=42", ss); end
    n_chk++; if (mm !== 8'h07) begin n_err++; $display("FAIL basic_mm got=%h exp=07", mm); end
    n_chk++; if (hh !== 8'h13) begin n_err++; $display("FAIL basic_hh got=%h exp=13", hh); end
  endtask

  task automatic test_convert_extremes();
    src_v = '{63, 0, 59};
    for (int i = 0; i < 2 * SP; i++) begin
      tick();
      n_chk++; if (en !== exp_en()) begin n_err++; $display("FAIL ext_en t=%0d got=%b exp=%b", t, en, exp_en()); end
      n_chk++; if (frame_done !== exp_fd()) begin n_err++; $display("FAIL ext_fd t=%0d got=%b exp=%b", t, frame_done, exp_fd()); end
      if (exp_fd()) break;
    end
    n_chk++; if (ss !== 8'h63) begin n_err++; $display("FAIL ext_ss got=%h exp=63", ss); end
    n_chk++; if (mm !== 8'h00) begin n_err++; $display("FAIL ext_mm got=%h exp=00", mm); end
    n_chk++; if (hh !== 8'h59) begin n_err++; $display("FAIL ext_hh got=%h exp=59", hh); end
  endtask

  task automatic test_select_glitch();
    for (int i = 0; i < 3; i++) src_v[i] = int'($urandom_range(0, 63));
    glitch_val = 6'd0;
    for (int v = 63; v >= 0; v--)
      if (v != src_v[0] && v != src_v[1] && v != src_v[2]) glitch_val = 6'(v);
    glitch_on = 1'b1;
    for (int i = 0; i < 2 * SP; i++) begin
      tick();
      if (exp_fd()) break;
    end
    glitch_on = 1'b0;
    n_chk++; if (ss !== bcd(src_v[0])) begin n_err++; $display("FAIL glitch_ss got=%h exp=%h", ss, bcd(src_v[0])); end
    n_chk++; if (mm !== bcd(src_v[1])) begin n_err++; $display("FAIL glitch_mm got=%h exp=%h", mm, bcd(src_v[1])); end
    n_chk++; if (hh !== bcd(src_v[2])) begin n_err++; $display("FAIL glitch_hh got=%h exp=%h", hh, bcd(src_v[2])); end
  endtask

  task automatic test_update_between();
    logic seen;
    src_v = '{5, 10, 20};
    for (int i = 0; i < 2 * SP; i++) begin
      tick();
      if (exp_fd()) break;
    end
    src_v = '{6, 11, 21};
    seen = 1'b0;
    for (int i = 0; i < 2 * SP; i++) begin
      tick();
      if (exp_fd()) seen = 1'b1;
      n_chk++;
      if ({ss, mm, hh} !== (seen ? {8'h06, 8'h11, 8'h21} : {8'h05, 8'h10, 8'h20})) begin
        n_err++; $display("FAIL upd_out t=%0d got=%h/%h/%h new=%b", t, ss, mm, hh, seen);
      end
      if (seen) break;
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 3; i++) src_v[i] = int'($urandom_range(0, 63));
      for (int i = 0; i < 2 * SP; i++) begin
        tick();
        n_chk++; if (en !== exp_en()) begin n_err++; $display("FAIL rnd_en t=%0d got=%b exp=%b", t, en, exp_en()); end
        n_chk++; if ({ss, mm, hh} !== {bcd(cv[0]), bcd(cv[1]), bcd(cv[2])}) begin
          n_err++; $display("FAIL rnd_out t=%0d got=%h/%h/%h exp=%h/%h/%h", t, ss, mm, hh, bcd(cv[0]), bcd(cv[1]), bcd(cv[2]));
        end
        n_chk++; if (seg !== exp_seg) begin n_err++; $display("FAIL rnd_seg t=%0d got=%h exp=%h", t, seg, exp_seg); end
        if (exp_fd()) break;
      end
    end
  endtask

  task automatic test_display();
    clear_n = 1'b0;
    src_v = '{42, 7, 13};
    tick();
    clear_n = 1'b1;
    for (int i = 0; i < 80; i++) begin
      tick();
      n_chk++; if (dig_sel !== exp_dig()) begin n_err++; $display("FAIL disp_dig t=%0d got=%b exp=%b", t, dig_sel, exp_dig()); end
      n_chk++; if (seg !== exp_seg) begin n_err++; $display("FAIL disp_seg t=%0d got=%h exp=%h", t, seg, exp_seg); end
      if (t >= 30 && (t / DP) % 6 == 0) begin
        n_chk++; if (seg !== 7'h5B) begin n_err++; $display("FAIL disp_two t=%0d got=%h exp=5b", t, seg); end
      end
      if (t >= 30 && (t / DP) % 6 == 1) begin
        n_chk++; if (seg !== 7'h66) begin n_err++; $display("FAIL disp_four t=%0d got=%h exp=66", t, seg); end
      end
    end
  endtask

  task automatic test_reset_mid();
    // stop inside the minute read, while its enable is high
    for (int i = 0; i < 2 * SP; i++) begin
      tick();
      if (t > 1 && (t - 1) % SP == 10) break;
    end
    n_chk++; if (en !== 3'b010) begin n_err++; $display("FAIL mid_pre_en got=%b exp=010", en); end
    clear_n = 1'b0;
    tick();
    n_chk++; if (en !== 3'b000) begin n_err++; $display("FAIL mid_en got=%b exp=000", en); end
    n_chk++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL mid_fd got=%b exp=0", frame_done); end
    n_chk++; if ({ss, mm, hh} !== 24'h0) begin n_err++; $display("FAIL mid_out got=%h/%h/%h exp=0", ss, mm, hh); end
    n_chk++; if (dig_sel !== 6'b000001 || seg !== 7'h3F) begin
      n_err++; $display("FAIL mid_disp got=%b/%h exp=000001/3f", dig_sel, seg);
    end
    clear_n = 1'b1;
    tick();
    n_chk++; if (en !== 3'b001) begin n_err++; $display("FAIL mid_restart_en got=%b exp=001", en); end
    for (int i = 0; i < 27; i++) begin
      tick();
      n_chk++; if (frame_done !== exp_fd()) begin n_err++; $display("FAIL mid_fd2 t=%0d got=%b exp=%b", t, frame_done, exp_fd()); end
    end
    n_chk++; if ({ss, mm, hh} !== {8'h42, 8'h07, 8'h13}) begin
      n_err++; $display("FAIL mid_final got=%h/%h/%h exp=42/07/13", ss, mm, hh);
    end
  endtask

  initial begin
    test_reset();
    test_basic_sweep();
    test_convert_extremes();
    test_select_glitch();
    test_update_between();
    test_random();
    test_display();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
